fetch_sequencer: RTL
====================

# fetch_sequencer

Controller for the MIPS instruction fetch stage. It owns the program counter and chooses the next fetch address from sequential, branch, jump and exception sources. It runs a request/ready handshake to instruction memory and holds fetched instructions in a one-entry skid buffer while decode is stalled. It drives the IF/ID-facing `Instruction`/`PCAddResult` registers and the IF/ID `Flush`, so the fetch path can tolerate multi-cycle memory and pipeline hazards.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: first fetch address after reset.
- `EXC_VECTOR`, default 32'h8000_0180: fetch address on exception.
- `Clk`  in  1  clock, all state updates on rising edge.
- `Reset`  in  1  synchronous, active-low reset; `Reset`=0 at an edge resets all state.
- `Stall`  in  1  hazard unit holds decode; output registers must not change.
- `Branch`  in  1  taken branch resolved this cycle.
- `BranchAddress`  in  32  branch target.
- `Jump`  in  1  jump resolved this cycle.
- `JumpAddress`  in  32  jump target.
- `Exception`  in  1  redirect to `EXC_VECTOR`.
- `MemReq`  out  1  instruction memory request.
- `MemAddr`  out  32  request address, word aligned.
- `MemReady`  in  1  memory returns `MemRdata` this cycle; may be the same cycle as `MemReq` (zero-wait).
- `MemRdata`  in  32  instruction word.
- `Instruction`  out  32  registered instruction to IF/ID.
- `PCAddResult`  out  32  registered address of `Instruction` + 4.
- `InstrValid`  out  1  `Instruction` is new this cycle.
- `Flush`  out  1  one-cycle IF/ID flush pulse.
- `PC`  out  32  next fetch address.

## Operation
- **Reset values:** state IDLE, `PC`=`RESET_VECTOR`, `MemReq`=0, `MemAddr`=`RESET_VECTOR`, `Instruction`=32'h0 (NOP), `PCAddResult`=0, `InstrValid`=0, `Flush`=0, skid empty.
- **Redirect priority:** `Exception` > `Branch` > `Jump` > sequential (`PC`+4).
- **Redirect override:** a redirect overrides `Stall`.
- **State IDLE:**
  - `MemReq`=0.
  - Always → FETCH next cycle.
  - A redirect in IDLE loads `PC`=target.
- **State FETCH:** `MemReq`=1, `MemAddr`=`PC`.
  - `MemReady`, no redirect, `Stall`=0: `Instruction`←`MemRdata`, `PCAddResult`←`MemAddr`+4, `InstrValid`←1, `PC`←`PC`+4; stay FETCH.
  - `MemReady`, `Stall`=1: skid←{`MemRdata`, `MemAddr`+4}, `PC`←`PC`+4; outputs hold; → SKID.
  - `MemReady`=0: if `Stall`=0 then `InstrValid`←0, else hold.
  - Redirect with `MemReady`=1: returned data dropped, `PC`←target; stay FETCH.
  - Redirect with `MemReady`=0: `PC`←target, `MemAddr` frozen; → DRAIN.
- **State SKID:** `MemReq`=0.
  - `Stall`=0: outputs←skid, `InstrValid`←1, skid cleared; → FETCH.
  - Redirect: skid dropped; → FETCH.
- **State DRAIN:** `MemReq`=1, `MemAddr` held at the abandoned address.
  - On `MemReady`: data discarded; → FETCH.
  - A further redirect in DRAIN replaces `PC` (latest wins).
- **Handshake rule:** once `MemReq`=1 without `MemReady`, `MemAddr` must not change until `MemReady`. Reset is the only exception.
- **Any redirect:**
  - Next cycle: `Flush`=1 for exactly one cycle and `InstrValid`=0.
  - `Instruction` reloads to NOP.
- **Arithmetic:** all addresses are 32-bit; +4 wraps modulo 2^32 (32'hFFFF_FFFC → 0). Bits [1:0] of redirect targets are forced to 0.

## Timing
- **Zero-wait throughput:** one instruction per cycle.
- **Zero-wait latency:** `MemReq`/`MemReady` at cycle t gives `Instruction`/`InstrValid` at t+1.
- **After reset:** `Reset` high at edge t0 puts `MemReq`=1 with `MemAddr`=`RESET_VECTOR` from t0+1 (IDLE occupies the cycle ending at t0+1).
- **Redirect, not DRAIN:** redirect at t gives `Flush`=1 and `MemAddr`=target at t+1. The target instruction appears at t+2 at the earliest.
- **Redirect, DRAIN:** the target request starts the cycle after the abandoned `MemReady`.
- **Stall:** `Stall` released at t in SKID gives the skid instruction at t+1 and a new `MemReq` at t+1.
- **Reset mid-operation:** `Reset`=0 at any edge abandons an outstanding request (`MemReq` drops next cycle), empties the skid and clears `Flush`.
- **Simultaneous events:**
  - `MemReady` with a redirect: redirect wins and the data is dropped.
  - `Stall` with a redirect: redirect wins.

## Structure
- Package `fetch_pkg`:
  - state enum {IDLE, FETCH, SKID, DRAIN};
  - `NOP` = 32'h0;
  - default vector constants.
- Sub-module `pc_next_select`: combinational priority mux of `Exception`/`Branch`/`Jump`/sequential. It outputs the target and a redirect flag and is reused by the exception unit.
- Top level: FSM, `PC`/`MemAddr`/output registers, skid register.

## Test plan
- **Reset and sequential fetch:** reset low 2 cycles then high; zero-wait memory returning `MemAddr`^32'hA5A5_0000 → `MemAddr` 0,4,8,C on consecutive cycles; `Instruction` matches one cycle later; `PCAddResult` 4,8,C,10.
- **Stall with skid:** `Stall`=1 for 3 cycles during a `MemReady` at address 8 → outputs hold the address-4 instruction, `MemReq`=0. On release, address-8 data is output with `PCAddResult`=C, then fetch resumes at C.
- **Branch during wait state:** memory 3-cycle latency; `Branch`=1 with `BranchAddress`=32'h40 in the first wait cycle → `MemAddr` stays 8 until `MemReady`, the data is discarded, the next `MemAddr`=32'h40, and `Flush` pulses exactly once.
- **Priority:** `Exception`, `Branch` (32'h100) and `Jump` (32'h200) in the same cycle → `MemAddr`=32'h8000_0180; `Jump` alone with misaligned 32'h203 → `MemAddr`=32'h200.
- **Wrap-around:** `Jump` to 32'hFFFF_FFFC → `PCAddResult`=0 and the next `MemAddr`=0.
- **Reset mid-DRAIN:** `Reset`=0 while in DRAIN → next cycle `MemReq`=0, `InstrValid`=0, `Flush`=0, `PC`=`RESET_VECTOR`; the stale `MemReady` afterwards is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NOP                = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEF_RESET_VECTOR   = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEF_EXC_VECTOR     = 32'h8000_0180;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SKID  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

   // One fetched instruction together with the address of the following word.
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc_add;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_select.sv
// Priority mux for the next fetch address: exception > branch > jump > sequential.
module pc_next_select
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
   input  logic [XLEN-1:0] pc_i,
   input  logic            exception_i,
   input  logic            branch_i,
   input  logic [XLEN-1:0] branch_addr_i,
   input  logic            jump_i,
   input  logic [XLEN-1:0] jump_addr_i,
   output logic [XLEN-1:0] target_c_o,
   output logic            redirect_c_o
);

   always_comb begin
      target_c_o   = pc_i + XLEN'(4);
      redirect_c_o = 1'b0;
      if (exception_i) begin
         target_c_o   = word_align(EXC_VECTOR);
         redirect_c_o = 1'b1;
      end else if (branch_i) begin
         target_c_o   = word_align(branch_addr_i);
         redirect_c_o = 1'b1;
      end else if (jump_i) begin
         target_c_o   = word_align(jump_addr_i);
         redirect_c_o = 1'b1;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// MIPS fetch-stage controller: owns PC, runs the imem handshake, skid-buffers under stall.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [XLEN-1:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Stall,
   input  logic            Branch,
   input  logic [XLEN-1:0] BranchAddress,
   input  logic            Jump,
   input  logic [XLEN-1:0] JumpAddress,
   input  logic            Exception,
   output logic            MemReq,
   output logic [XLEN-1:0] MemAddr,
   input  logic            MemReady,
   input  logic [XLEN-1:0] MemRdata,
   output logic [XLEN-1:0] Instruction,
   output logic [XLEN-1:0] PCAddResult,
   output logic            InstrValid,
   output logic            Flush,
   output logic [XLEN-1:0] PC
);

   fetch_state_e    state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] mem_addr_q;
   logic            mem_req_q;
   logic [XLEN-1:0] instr_q;
   logic [XLEN-1:0] pc_add_q;
   logic            valid_q;
   logic            flush_q;
   fetch_entry_t    skid_q;

   logic [XLEN-1:0] target_d;
   logic            redirect_c;

   pc_next_select #(
      .EXC_VECTOR (EXC_VECTOR)
   ) u_pc_next_select (
      .pc_i          (pc_q),
      .exception_i   (Exception),
      .branch_i      (Branch),
      .branch_addr_i (BranchAddress),
      .jump_i        (Jump),
      .jump_addr_i   (JumpAddress),
      .target_c_o    (target_d),
      .redirect_c_o  (redirect_c)
   );

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_VECTOR;
         mem_addr_q <= RESET_VECTOR;
         mem_req_q  <= 1'b0;
         instr_q    <= NOP;
         pc_add_q   <= '0;
         valid_q    <= 1'b0;
         flush_q    <= 1'b0;
         skid_q     <= '0;
      end else begin
         // A redirect overrides Stall in every state: flush IF/ID and retarget PC.
         flush_q <= redirect_c;
         if (redirect_c) begin
            pc_q    <= target_d;
            instr_q <= NOP;
            valid_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               state_q    <= FETCH;
               mem_req_q  <= 1'b1;
               mem_addr_q <= redirect_c ? target_d : pc_q;
            end
            FETCH: begin
               if (redirect_c) begin
                  // MemAddr must stay put until the outstanding request completes.
                  if (MemReady) mem_addr_q <= target_d;
                  else          state_q    <= DRAIN;
               end else if (MemReady) begin
                  pc_q       <= target_d;
                  mem_addr_q <= target_d;
                  if (Stall) begin
                     skid_q    <= '{instr: MemRdata, pc_add: mem_addr_q + XLEN'(4)};
                     mem_req_q <= 1'b0;
                     state_q   <= SKID;
                  end else begin
                     instr_q  <= MemRdata;
                     pc_add_q <= mem_addr_q + XLEN'(4);
                     valid_q  <= 1'b1;
                  end
               end else if (!Stall) begin
                  valid_q <= 1'b0;
               end
            end
            SKID: begin
               if (redirect_c) begin
                  mem_addr_q <= target_d;
                  mem_req_q  <= 1'b1;
                  state_q    <= FETCH;
               end else if (!Stall) begin
                  instr_q   <= skid_q.instr;
                  pc_add_q  <= skid_q.pc_add;
                  valid_q   <= 1'b1;
                  mem_req_q <= 1'b1;
                  state_q   <= FETCH;
               end
            end
            DRAIN: begin
               // Abandoned response is discarded; latest redirect target wins.
               if (MemReady) begin
                  mem_addr_q <= redirect_c ? target_d : pc_q;
                  state_q    <= FETCH;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign MemReq      = mem_req_q;
   assign MemAddr     = mem_addr_q;
   assign Instruction = instr_q;
   assign PCAddResult = pc_add_q;
   assign InstrValid  = valid_q;
   assign Flush       = flush_q;
   assign PC          = pc_q;

endmodule
